// File: rtl/jump_sequencer.sv
// Navigation command front-end: accepts origin/sublight/jump commands and drives the position stage.
// Optional macro JUMP_ABORT_EN adds an abort input that cancels a jump while it is charging.
module jump_sequencer #(
    parameter int K             = 16,
    parameter int CHARGE_CYCLES = 4,
    parameter int COOL_CYCLES   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [3*K-1:0]   cmd_vec,
    output logic [3:0]       pos_mode,
    output logic [3*K-1:0]   jump_position,
    output logic [3*K-1:0]   velocity,
    output logic             busy,
    output logic             jump_done
`ifdef JUMP_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [2:0] {
        S_ORIGIN,
        S_IDLE,
        S_CHARGE,
        S_JUMP,
        S_COOL
    } state_t;

    localparam logic [7:0] CHARGE_LOAD = 8'(CHARGE_CYCLES - 1);
    localparam logic [7:0] COOL_LOAD   = 8'(COOL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3*K-1:0]   vel_q, vel_d;
    logic [3*K-1:0]   tgt_q, tgt_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [3:0]       pos_mode_q, pos_mode_d;
    logic [3*K-1:0]   jump_position_q, jump_position_d;
    logic [3*K-1:0]   velocity_q, velocity_d;
    logic             busy_q, busy_d;
    logic             jump_done_q, jump_done_d;
    logic             cmd_ready_q, cmd_ready_d;

    logic             abort_w;
    logic             accept;

`ifdef JUMP_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_ORIGIN: state_d = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    case (cmd_type)
                        2'b00: begin
                            vel_d   = '0;
                            state_d = S_ORIGIN;
                        end
                        2'b01: vel_d = cmd_vec;
                        2'b10: begin
                            tgt_d   = cmd_vec;
                            cnt_d   = CHARGE_LOAD;
                            state_d = S_CHARGE;
                        end
                        default: ;
                    endcase
                end
            end
            S_CHARGE: begin
                if (abort_w) begin
                    vel_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_JUMP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_JUMP: begin
                cnt_d   = COOL_LOAD;
                state_d = S_COOL;
            end
            S_COOL: begin
                // The ship is left stationary once the jump sequence finishes.
                if (cnt_q == 8'd0) begin
                    vel_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_ORIGIN;
        endcase

        if (rst) begin
            state_d = S_ORIGIN;
            vel_d   = '0;
            tgt_d   = '0;
            cnt_d   = '0;
        end

        // Outputs are registered from the next state so they line up with state_q.
        case (state_d)
            S_ORIGIN: pos_mode_d = 4'b0001;
            S_JUMP:   pos_mode_d = 4'b0100;
            default:  pos_mode_d = 4'b0010;
        endcase
        velocity_d      = (state_d == S_IDLE) ? vel_d : '0;
        jump_position_d = (state_d == S_JUMP) ? tgt_d : jump_position_q;
        if (rst) begin
            jump_position_d = '0;
        end
        busy_d      = (state_d != S_IDLE);
        jump_done_d = (state_d == S_JUMP);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        state_q         <= state_d;
        vel_q           <= vel_d;
        tgt_q           <= tgt_d;
        cnt_q           <= cnt_d;
        pos_mode_q      <= pos_mode_d;
        jump_position_q <= jump_position_d;
        velocity_q      <= velocity_d;
        busy_q          <= busy_d;
        jump_done_q     <= jump_done_d;
        cmd_ready_q     <= cmd_ready_d;
    end

    assign pos_mode      = pos_mode_q;
    assign jump_position = jump_position_q;
    assign velocity      = velocity_q;
    assign busy          = busy_q;
    assign jump_done     = jump_done_q;
    assign cmd_ready     = cmd_ready_q;

endmodule
